cond_exec_ctrl: RTL and testbench
=================================

# cond_exec_ctrl

Sequencing controller for conditional instruction execution. Owns the architectural NZCV flags register and evaluates each incoming instruction's 4-bit condition code against it. Launches the ALU only for instructions whose condition passes and squashes the rest. Writes ALU-returned flags back for flag-setting instructions, so the next instruction always sees up-to-date flags (no flag hazard).

## Interface
- `TIMEOUT`, default 16: cycles `BUSY` may wait for `alu_done` before aborting; only used with `COND_CTRL_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: controller can accept; `in_valid && in_ready` at a rising edge = accept.
- `in_cond` in 4: condition code.
- `in_setf` in 1: instruction updates flags on completion.
- `alu_go` out 1: one-cycle ALU launch pulse.
- `alu_done` in 1: ALU result valid, sampled only in `BUSY`.
- `alu_flags` in 4: new flags `[N=3,Z=2,C=1,V=0]`, valid with `alu_done`.
- `exec_valid` out 1: one-cycle completion pulse per accepted instruction.
- `exec_en` out 1: qualifies `exec_valid`; 1 = executed/commit, 0 = squashed.
- `flags` out 4: current flags register.
- `timeout_err` out 1: one-cycle abort pulse; tied 0 without the macro.

## Operation
- **Conditions**, using flags N, Z, C, V:
  - `0000` AL: always.
  - `0001` EQ: Z.
  - `0010` GT: !Z && N==V.
  - `0011` LT: N!=V.
  - `0100` GE: N==V.
  - `0101` LE: Z || N!=V.
  - `0110` HI: C && !Z.
  - `0111` LO: !C.
  - `1000` HS: C.
  - `1001`–`1111`: never pass (squash).
- **States:** `IDLE`, `BUSY`.
- **`IDLE`**
  - `in_ready` = 1.
  - On accept, the condition is evaluated against the `flags` register value in the accept cycle.
  - Pass: latch `in_setf`, go to `BUSY`, and assert `alu_go` in the next cycle.
  - Fail: stay in `IDLE`; `exec_valid`=1 and `exec_en`=0 in the next cycle. The flags register is unchanged, even if `in_setf`=1.
- **`BUSY`**
  - `in_ready` = 0.
  - On `alu_done`: if the latched `setf` is 1, `flags <= alu_flags` at that edge. `exec_valid`=1 and `exec_en`=1 in the next cycle; go to `IDLE`.
- `alu_done` outside `BUSY` is ignored.
- `in_ready` is combinational: `state == IDLE`. All other outputs are registered.
- **Reset values:**
  - `flags`=0000, `alu_go`=0, `exec_valid`=0, `exec_en`=0, `timeout_err`=0.
  - State = `IDLE`, so `in_ready`=1 in the first cycle after reset.
- **Reset mid-operation:** `rst` has priority over every event. A `BUSY` instruction is dropped with no `exec_valid`; a later `alu_done` is ignored.

## Timing
- **Squash path:** accept at edge T → `exec_valid` in cycle T+1. Sustains one instruction per cycle.
- **Execute path:** accept at edge T → `alu_go` high in cycle T+1 only.
  - `alu_done` may be sampled at edge T+1 at the earliest, i.e. a same-cycle response to `alu_go` is legal.
  - `alu_done` at edge D → `flags` updated from cycle D+1, `exec_valid` in D+1, and `in_ready` high in D+1.
  - Minimum period for executed instructions is 2 cycles.
- **Back-to-back:** an instruction accepted in cycle D+1 evaluates against the flags written at D.
- `alu_flags` is ignored when `alu_done`=0 or when the latched `setf`=0.

## Configuration
- **`COND_CTRL_TIMEOUT_EN` defined:**
  - A counter is cleared on entry to `BUSY` and increments every `BUSY` cycle without `alu_done`.
  - After `TIMEOUT` such cycles: `exec_valid`=1, `exec_en`=0, `timeout_err`=1 for one cycle, flags unchanged, return to `IDLE`.
  - `alu_done` on the same edge as expiry wins; the instruction completes normally.
- **Undefined:** no counter; `BUSY` waits indefinitely; `timeout_err` is constant 0.

## Structure
- **Shared package `cond_pkg`:**
  - Condition-code constants `COND_AL`…`COND_HS`.
  - Flag bit indices `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
  - State encoding `IDLE`/`BUSY`.
- **Sub-module `cond_eval`:** purely combinational (`cond`[4], `flags`[4] → `pass`[1]), reusable by other conditional units.

## Test plan
- After reset, `in_cond`=0001 (EQ), flags=0000 → `exec_valid`=1 and `exec_en`=0 next cycle; no `alu_go`; flags stay 0000.
- AL with `setf`=1, ALU answers after 3 cycles with `alu_flags`=0100 → one `alu_go` pulse, `exec_en`=1, flags=0100, then an immediately following EQ executes.
- Flags=1000 (N=1, V=0): LT executes, GE squashes, LE executes; flags=0010: HI executes, LO squashes, HS executes; codes 1001–1111 all squash.
- Executed instruction with `setf`=0, `alu_flags`=1111 → flags unchanged. Squashed instruction with `setf`=1 → flags unchanged. A stray `alu_done` in `IDLE` → no effect.
- `rst` asserted while `BUSY`, then `alu_done` → no `exec_valid`; flags=0000; `in_ready`=1.
- With macro, `TIMEOUT`=4 and no `alu_done` → abort pulse (`exec_en`=0, `timeout_err`=1) after 4 `BUSY` cycles. `alu_done` on the expiry edge → normal completion with `timeout_err`=0.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared definitions for conditional-execution units: condition codes,
// NZCV flag bit positions and the controller state encoding.
package cond_pkg;

    localparam logic [3:0] COND_AL = 4'b0000;
    localparam logic [3:0] COND_EQ = 4'b0001;
    localparam logic [3:0] COND_GT = 4'b0010;
    localparam logic [3:0] COND_LT = 4'b0011;
    localparam logic [3:0] COND_GE = 4'b0100;
    localparam logic [3:0] COND_LE = 4'b0101;
    localparam logic [3:0] COND_HI = 4'b0110;
    localparam logic [3:0] COND_LO = 4'b0111;
    localparam logic [3:0] COND_HS = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether an instruction
// with code `cond` executes under the given NZCV flags.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_AL: pass = 1'b1;
            COND_EQ: pass = z;
            COND_GT: pass = !z && (n == v);
            COND_LT: pass = (n != v);
            COND_GE: pass = (n == v);
            COND_LE: pass = z || (n != v);
            COND_HI: pass = c && !z;
            COND_LO: pass = !c;
            COND_HS: pass = c;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_ctrl.sv
// Conditional-execution sequencer owning the NZCV flags register.
// Define COND_CTRL_TIMEOUT_EN to abort a BUSY instruction after TIMEOUT cycles.
module cond_exec_ctrl
    import cond_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_cond,
    input  logic       in_setf,
    output logic       alu_go,
    input  logic       alu_done,
    input  logic [3:0] alu_flags,
    output logic       exec_valid,
    output logic       exec_en,
    output logic [3:0] flags,
    output logic       timeout_err
);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_e     state_q, state_d;
    logic       setf_q, setf_d;
    logic [3:0] flags_q, flags_d;
    logic       alu_go_q, alu_go_d;
    logic       exec_valid_q, exec_valid_d;
    logic       exec_en_q, exec_en_d;
    logic       timeout_err_q, timeout_err_d;
    logic       cond_pass;

`ifdef COND_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    cond_eval u_cond_eval (
        .cond  (in_cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    always_comb begin
        state_d       = state_q;
        setf_d        = setf_q;
        flags_d       = flags_q;
        alu_go_d      = 1'b0;
        exec_valid_d  = 1'b0;
        exec_en_d     = 1'b0;
        timeout_err_d = 1'b0;
`ifdef COND_CTRL_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (cond_pass) begin
                        state_d  = BUSY;
                        setf_d   = in_setf;
                        alu_go_d = 1'b1;
`ifdef COND_CTRL_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end else begin
                        exec_valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // A response on the expiry edge still completes normally.
                if (alu_done) begin
                    if (setf_q) flags_d = alu_flags;
                    exec_valid_d = 1'b1;
                    exec_en_d    = 1'b1;
                    state_d      = IDLE;
                end
`ifdef COND_CTRL_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    exec_valid_d  = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            setf_q        <= 1'b0;
            flags_q       <= 4'b0000;
            alu_go_q      <= 1'b0;
            exec_valid_q  <= 1'b0;
            exec_en_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef COND_CTRL_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            setf_q        <= setf_d;
            flags_q       <= flags_d;
            alu_go_q      <= alu_go_d;
            exec_valid_q  <= exec_valid_d;
            exec_en_q     <= exec_en_d;
            timeout_err_q <= timeout_err_d;
`ifdef COND_CTRL_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign alu_go      = alu_go_q;
    assign exec_valid  = exec_valid_q;
    assign exec_en     = exec_en_q;
    assign flags       = flags_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed-vector bench for cond_exec_ctrl; exercises the timeout path
// only when COND_CTRL_TIMEOUT_EN is defined.
module tb_cond_exec_ctrl;
    import cond_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_cond;
    logic       in_setf;
    logic       alu_go;
    logic       alu_done;
    logic [3:0] alu_flags;
    logic       exec_valid;
    logic       exec_en;
    logic [3:0] flags;
    logic       timeout_err;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] cur_flags;

    cond_exec_ctrl #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cond     (in_cond),
        .in_setf     (in_setf),
        .alu_go      (alu_go),
        .alu_done    (alu_done),
        .alu_flags   (alu_flags),
        .exec_valid  (exec_valid),
        .exec_en     (exec_en),
        .flags       (flags),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load flags via an executed AL instruction with setf=1.
    task automatic set_flags(input logic [3:0] f);
        in_valid = 1'b1; in_cond = COND_AL; in_setf = 1'b1;
        tick();
        in_valid = 1'b0; in_setf = 1'b0;
        chk("setf_go", 8'(alu_go), 8'd1);
        alu_done = 1'b1; alu_flags = f;
        tick();
        alu_done = 1'b0;
        chk("setf_ev", 8'(exec_valid), 8'd1);
        chk("setf_en", 8'(exec_en), 8'd1);
        chk("setf_flags", 8'(flags), 8'(f));
        cur_flags = f;
    endtask

    // Offer one instruction; executed ones get an immediate ALU answer
    // carrying inverted flags so any unwanted write-back shows up.
    task automatic issue(input logic [3:0] c, input logic s, input logic exp_pass);
        string tag;
        tag = $sformatf("c%0h_f%0h", c, cur_flags);
        in_valid = 1'b1; in_cond = c; in_setf = s;
        chk({tag, "_rdy"}, 8'(in_ready), 8'd1);
        tick();
        in_valid = 1'b0; in_setf = 1'b0;
        if (exp_pass) begin
            chk({tag, "_go"}, 8'(alu_go), 8'd1);
            chk({tag, "_ev0"}, 8'(exec_valid), 8'd0);
            chk({tag, "_busy"}, 8'(in_ready), 8'd0);
            alu_done = 1'b1; alu_flags = ~cur_flags;
            tick();
            alu_done = 1'b0;
            chk({tag, "_ev"}, 8'(exec_valid), 8'd1);
            chk({tag, "_en"}, 8'(exec_en), 8'd1);
            if (s) cur_flags = ~cur_flags;
        end else begin
            chk({tag, "_nogo"}, 8'(alu_go), 8'd0);
            chk({tag, "_ev"}, 8'(exec_valid), 8'd1);
            chk({tag, "_sq"}, 8'(exec_en), 8'd0);
        end
        chk({tag, "_flags"}, 8'(flags), 8'(cur_flags));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cond = 4'h0; in_setf = 1'b0;
        alu_done = 1'b0; alu_flags = 4'h0; cur_flags = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_flags", 8'(flags), 8'h0);
        chk("rst_go", 8'(alu_go), 8'd0);
        chk("rst_ev", 8'(exec_valid), 8'd0);
        chk("rst_en", 8'(exec_en), 8'd0);
        chk("rst_to", 8'(timeout_err), 8'd0);
        chk("rst_rdy", 8'(in_ready), 8'd1);

        // EQ with Z=0 squashes; squash with setf=1 leaves flags alone
        issue(COND_EQ, 1'b0, 1'b0);
        issue(COND_EQ, 1'b1, 1'b0);

        // AL setf=1, ALU answers in the third BUSY cycle
        in_valid = 1'b1; in_cond = COND_AL; in_setf = 1'b1;
        tick();
        in_valid = 1'b0; in_setf = 1'b0;
        chk("al_go1", 8'(alu_go), 8'd1);
        chk("al_rdy1", 8'(in_ready), 8'd0);
        tick();
        chk("al_go2", 8'(alu_go), 8'd0);
        chk("al_ev2", 8'(exec_valid), 8'd0);
        tick();
        chk("al_go3", 8'(alu_go), 8'd0);
        chk("al_rdy3", 8'(in_ready), 8'd0);
        alu_done = 1'b1; alu_flags = 4'b0100;
        tick();
        alu_done = 1'b0;
        chk("al_ev", 8'(exec_valid), 8'd1);
        chk("al_en", 8'(exec_en), 8'd1);
        chk("al_flags", 8'(flags), 8'h4);
        chk("al_go_end", 8'(alu_go), 8'd0);
        cur_flags = 4'b0100;
        // back-to-back EQ sees the freshly written Z
        issue(COND_EQ, 1'b0, 1'b1);

        // N=1, V=0
        set_flags(4'b1000);
        issue(COND_LT, 1'b0, 1'b1);
        issue(COND_GE, 1'b0, 1'b0);
        issue(COND_LE, 1'b0, 1'b1);
        issue(COND_GT, 1'b0, 1'b0);
        issue(COND_EQ, 1'b0, 1'b0);
        issue(COND_HI, 1'b0, 1'b0);
        issue(COND_LO, 1'b0, 1'b1);
        issue(COND_HS, 1'b0, 1'b0);
        issue(COND_AL, 1'b0, 1'b1);

        // C=1
        set_flags(4'b0010);
        issue(COND_HI, 1'b0, 1'b1);
        issue(COND_LO, 1'b0, 1'b0);
        issue(COND_HS, 1'b0, 1'b1);
        issue(COND_GT, 1'b0, 1'b1);
        issue(COND_LT, 1'b0, 1'b0);
        issue(COND_GE, 1'b0, 1'b1);
        issue(COND_LE, 1'b0, 1'b0);

        // Z=1, V=1
        set_flags(4'b0101);
        issue(COND_GT, 1'b0, 1'b0);
        issue(COND_LT, 1'b0, 1'b1);
        issue(COND_GE, 1'b0, 1'b0);
        issue(COND_LE, 1'b0, 1'b1);
        issue(COND_EQ, 1'b0, 1'b1);
        issue(COND_HI, 1'b0, 1'b0);

        // N=1, V=1
        set_flags(4'b1001);
        issue(COND_GT, 1'b0, 1'b1);
        issue(COND_GE, 1'b0, 1'b1);
        issue(COND_LT, 1'b0, 1'b0);
        issue(COND_LE, 1'b0, 1'b0);

        // reserved codes never pass, even with every flag set
        set_flags(4'b1111);
        for (int c = 9; c < 16; c++) issue(4'(c), 1'b1, 1'b0);

        // executed setf=1 writes back (inverted flags)
        issue(COND_AL, 1'b1, 1'b1);

        // one squash per cycle
        in_valid = 1'b1; in_cond = 4'hF;
        tick();
        chk("b2b_ev1", 8'(exec_valid), 8'd1);
        chk("b2b_rdy1", 8'(in_ready), 8'd1);
        tick();
        chk("b2b_ev2", 8'(exec_valid), 8'd1);
        chk("b2b_en2", 8'(exec_en), 8'd0);
        in_valid = 1'b0;
        tick();
        chk("b2b_idle", 8'(exec_valid), 8'd0);

        // stray alu_done in IDLE
        alu_done = 1'b1; alu_flags = ~cur_flags;
        tick();
        alu_done = 1'b0;
        chk("stray_ev", 8'(exec_valid), 8'd0);
        chk("stray_flags", 8'(flags), 8'(cur_flags));
        chk("stray_rdy", 8'(in_ready), 8'd1);

        // reset while BUSY drops the instruction
        in_valid = 1'b1; in_cond = COND_AL; in_setf = 1'b1;
        tick();
        in_valid = 1'b0; in_setf = 1'b0;
        chk("rb_busy", 8'(in_ready), 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        alu_done = 1'b1; alu_flags = 4'b1111;
        tick();
        alu_done = 1'b0;
        chk("rb_ev", 8'(exec_valid), 8'd0);
        chk("rb_flags", 8'(flags), 8'h0);
        chk("rb_rdy", 8'(in_ready), 8'd1);
        cur_flags = 4'h0;

`ifdef COND_CTRL_TIMEOUT_EN
        set_flags(4'b0110);
        in_valid = 1'b1; in_cond = COND_AL; in_setf = 1'b1;
        tick();
        in_valid = 1'b0; in_setf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_ev", 8'(exec_valid), 8'd0);
            chk("to_wait_rdy", 8'(in_ready), 8'd0);
        end
        tick();
        chk("to_ev", 8'(exec_valid), 8'd1);
        chk("to_en", 8'(exec_en), 8'd0);
        chk("to_err", 8'(timeout_err), 8'd1);
        chk("to_flags", 8'(flags), 8'h6);
        chk("to_rdy", 8'(in_ready), 8'd1);
        tick();
        chk("to_err_pulse", 8'(timeout_err), 8'd0);
        // response on the expiry edge wins
        in_valid = 1'b1; in_cond = COND_AL; in_setf = 1'b1;
        tick();
        in_valid = 1'b0; in_setf = 1'b0;
        tick(); tick(); tick();
        alu_done = 1'b1; alu_flags = 4'b1001;
        tick();
        alu_done = 1'b0;
        chk("tw_ev", 8'(exec_valid), 8'd1);
        chk("tw_en", 8'(exec_en), 8'd1);
        chk("tw_err", 8'(timeout_err), 8'd0);
        chk("tw_flags", 8'(flags), 8'h9);
`else
        // without the timeout, BUSY waits as long as needed
        in_valid = 1'b1; in_cond = COND_AL; in_setf = 1'b1;
        tick();
        in_valid = 1'b0; in_setf = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("nto_ev", 8'(exec_valid), 8'd0);
        chk("nto_err", 8'(timeout_err), 8'd0);
        chk("nto_busy", 8'(in_ready), 8'd0);
        alu_done = 1'b1; alu_flags = 4'b1001;
        tick();
        alu_done = 1'b0;
        chk("nto_done_en", 8'(exec_en), 8'd1);
        chk("nto_flags", 8'(flags), 8'h9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
